// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a ready/valid handshake on both sides.
// S1 captures the operation; S2 computes, registers the result and flags, and updates the accumulator.
module alu_pipe #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              ci,
    input  logic              bi,
    input  logic [OP_W-1:0]   opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   result_out,
    output logic              c_out,
    output logic              sign_b,
    output logic              zero_b,
    output logic              parity_b,
    output logic              overflow
);

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OP_W-1:0] OP_ASR  = 4'h8;
    localparam logic [OP_W-1:0] OP_ROL  = 4'h9;
    localparam logic [OP_W-1:0] OP_ROR  = 4'hA;
    localparam logic [OP_W-1:0] OP_INC  = 4'hB;
    localparam logic [OP_W-1:0] OP_DEC  = 4'hC;
    localparam logic [OP_W-1:0] OP_PASS = 4'hD;
    localparam logic [OP_W-1:0] OP_CMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_ACC  = 4'hF;

    localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]   ONE_X = {{DATA_W{1'b0}}, 1'b1};

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_ci;
    logic              r_bi;
    logic [OP_W-1:0]   r_op;

    logic              r_s2_valid;
    logic [DATA_W:0]   r_result;
    logic              r_c;
    logic              r_sign;
    logic              r_zero;
    logic              r_parity;
    logic              r_ovf;
    logic [DATA_W-1:0] r_acc;

    logic              w_advance;
    logic              w_take;
    logic [DATA_W:0]   w_ax;
    logic [DATA_W:0]   w_bx;
    logic [DATA_W:0]   w_full;
    logic [DATA_W:0]   w_res;
    logic              w_ovf;
    logic              w_is_cmp;

    function automatic logic add_ovf(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                     input logic s_msb);
        return (x[DATA_W-1] == y[DATA_W-1]) && (s_msb != x[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                     input logic s_msb);
        return (x[DATA_W-1] != y[DATA_W-1]) && (s_msb != x[DATA_W-1]);
    endfunction

    function automatic logic parity_of(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    assign w_advance = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_advance;
    assign w_take    = in_valid && in_ready;

    // Operation decode: w_full is the value flags are derived from; CMP keeps it but drives a zero result
    always_comb begin
        w_ax     = {1'b0, r_a};
        w_bx     = {1'b0, r_b};
        w_full   = '0;
        w_ovf    = 1'b0;
        w_is_cmp = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_full = w_ax + w_bx + {{DATA_W{1'b0}}, r_ci};
                w_ovf  = add_ovf(r_a, r_b, w_full[DATA_W-1]);
            end
            OP_SUB: begin
                w_full = w_ax - w_bx - {{DATA_W{1'b0}}, r_bi};
                w_ovf  = sub_ovf(r_a, r_b, w_full[DATA_W-1]);
            end
            OP_AND:  w_full = {1'b0, r_a & r_b};
            OP_OR:   w_full = {1'b0, r_a | r_b};
            OP_XOR:  w_full = {1'b0, r_a ^ r_b};
            OP_NOT:  w_full = {1'b0, ~r_a};
            OP_SHL:  w_full = {r_a, 1'b0};
            OP_SHR:  w_full = {r_a[0], 1'b0, r_a[DATA_W-1:1]};
            OP_ASR:  w_full = {r_a[0], r_a[DATA_W-1], r_a[DATA_W-1:1]};
            OP_ROL:  w_full = {r_a[DATA_W-1], r_a[DATA_W-2:0], r_a[DATA_W-1]};
            OP_ROR:  w_full = {r_a[0], r_a[0], r_a[DATA_W-1:1]};
            OP_INC: begin
                w_full = w_ax + ONE_X;
                w_ovf  = add_ovf(r_a, ONE_D, w_full[DATA_W-1]);
            end
            OP_DEC: begin
                w_full = w_ax - ONE_X;
                w_ovf  = sub_ovf(r_a, ONE_D, w_full[DATA_W-1]);
            end
            OP_PASS: w_full = {1'b0, r_b};
            OP_CMP: begin
                w_full   = w_ax - w_bx - {{DATA_W{1'b0}}, r_bi};
                w_ovf    = sub_ovf(r_a, r_b, w_full[DATA_W-1]);
                w_is_cmp = 1'b1;
            end
            OP_ACC: begin
                w_full = {1'b0, r_acc} + w_ax;
                w_ovf  = add_ovf(r_acc, r_a, w_full[DATA_W-1]);
            end
            default: w_full = '0;
        endcase
        if (w_is_cmp) begin
            w_res = '0;
        end else begin
            w_res = w_full;
        end
    end

    // Stage 1: capture the operation; a same-edge advance and take simply replaces the contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_ci       <= 1'b0;
            r_bi       <= 1'b0;
            r_op       <= '0;
        end else if (w_take) begin
            r_s1_valid <= 1'b1;
            r_a        <= a_in;
            r_b        <= b_in;
            r_ci       <= ci;
            r_bi       <= bi;
            r_op       <= opcode;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: register result, flags and accumulator; hold everything while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_c        <= 1'b0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else if (w_advance) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_res;
            r_c        <= w_full[DATA_W];
            r_sign     <= w_full[DATA_W-1];
            r_zero     <= (w_full[DATA_W-1:0] == '0);
            r_parity   <= parity_of(w_full[DATA_W-1:0]);
            r_ovf      <= w_ovf;
            if (!w_is_cmp) begin
                r_acc <= w_full[DATA_W-1:0];
            end
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid  = r_s2_valid;
    assign result_out = r_result;
    assign c_out      = r_c;
    assign sign_b     = r_sign;
    assign zero_b     = r_zero;
    assign parity_b   = r_parity;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DATA_W=8): fixed vectors, handshake corner sequences
// and randomized traffic against an arithmetic reference model with an in-order result queue.
module tb_alu_pipe;

    typedef struct packed {
        logic [8:0] res;
        logic       c;
        logic       s;
        logic       z;
        logic       p;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       bi;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       ci;
    logic       bi;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] result_out;
    logic       c_out;
    logic       sign_b;
    logic       zero_b;
    logic       parity_b;
    logic       overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [7:0] m_acc;
    logic rand_rdy;
    vec_t tbl[17];

    alu_pipe #(.DATA_W(8), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .ci(ci), .bi(bi), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .c_out(c_out), .sign_b(sign_b), .zero_b(zero_b), .parity_b(parity_b),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [8:0] r, input logic c, input logic s,
                                input logic z, input logic p, input logic ov);
        exp_t e;
        e.res = r; e.c = c; e.s = s; e.z = z; e.p = p; e.ov = ov;
        return e;
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic c_i, input logic b_i, input logic [7:0] acc);
        int ua = int'(a);
        int ub = int'(b);
        int uc = int'(acc);
        int sa = (ua > 127) ? ua - 256 : ua;
        int sb = (ub > 127) ? ub - 256 : ub;
        int sc = (uc > 127) ? uc - 256 : uc;
        int r = 0;
        int sr = 0;
        bit arith = 1'b0;
        bit cmp = 1'b0;
        logic [8:0] v;
        logic [7:0] low;
        exp_t e;
        case (op)
            4'h0: begin r = ua + ub + int'(c_i); sr = sa + sb + int'(c_i); arith = 1'b1; end
            4'h1: begin r = ua - ub - int'(b_i); sr = sa - sb - int'(b_i); arith = 1'b1; end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: r = 255 - ua;
            4'h6: r = ua * 2;
            4'h7: r = ua / 2 + (ua % 2) * 256;
            4'h8: r = ((sa >>> 1) & 255) + (ua % 2) * 256;
            4'h9: r = (ua * 2) % 256 + ua / 128 + (ua / 128) * 256;
            4'hA: r = ua / 2 + (ua % 2) * 128 + (ua % 2) * 256;
            4'hB: begin r = ua + 1; sr = sa + 1; arith = 1'b1; end
            4'hC: begin r = ua - 1; sr = sa - 1; arith = 1'b1; end
            4'hD: r = ub;
            4'hE: begin r = ua - ub - int'(b_i); sr = sa - sb - int'(b_i); arith = 1'b1; cmp = 1'b1; end
            default: begin r = uc + ua; sr = sc + sa; arith = 1'b1; end
        endcase
        v    = r[8:0];
        low  = v[7:0];
        e.c  = v[8];
        e.s  = low[7];
        e.z  = (low == 8'h00);
        e.p  = ($countones(low) % 2) == 1;
        e.ov = arith && (sr > 127 || sr < -128);
        e.res = cmp ? 9'h000 : v;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [3:0] op, input exp_t e);
        exp_q.push_back(e);
        if (op != 4'hE) m_acc = e.res[7:0];
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c_i, input logic b_i);
        in_valid = 1'b1; opcode = op; a_in = a; b_in = b; ci = c_i; bi = b_i;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c_i, input logic b_i, input exp_t e);
        drive(op, a, b, c_i, b_i);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                push(op, e);
                tick();
                return;
            end
            tick();
        end
        checks++;
        failures++;
        $display("FAIL issue_timeout: in_ready stayed 0 for 200 cycles, op=%h", op);
    endtask

    task automatic issue_m(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic c_i, input logic b_i);
        issue(op, a, b, c_i, b_i, model(op, a, b, c_i, b_i, m_acc));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
        tick();
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Output monitor: every valid cycle must show the oldest outstanding result, held across stalls
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: actual res=%h with no result outstanding", result_out);
            end else begin
                chk("result_flags", {result_out, c_out, sign_b, zero_b, parity_b, overflow},
                    exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        tbl[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, mk(9'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[1]  = '{4'h1, 8'h80, 8'h01, 1'b0, 1'b0, mk(9'h07F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
        tbl[2]  = '{4'hA, 8'h01, 8'h00, 1'b0, 1'b0, mk(9'h180, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)};
        tbl[3]  = '{4'h8, 8'h80, 8'h00, 1'b0, 1'b0, mk(9'h0C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{4'h0, 8'h7F, 8'h00, 1'b1, 1'b0, mk(9'h080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[5]  = '{4'h1, 8'h00, 8'h01, 1'b0, 1'b0, mk(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{4'h6, 8'h81, 8'h00, 1'b0, 1'b0, mk(9'h102, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[7]  = '{4'h7, 8'h81, 8'h00, 1'b0, 1'b0, mk(9'h140, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[8]  = '{4'h9, 8'h80, 8'h00, 1'b0, 1'b0, mk(9'h101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[9]  = '{4'h4, 8'hA5, 8'h5A, 1'b0, 1'b0, mk(9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{4'hB, 8'h7F, 8'h00, 1'b0, 1'b0, mk(9'h080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[11] = '{4'hC, 8'h00, 8'h00, 1'b0, 1'b0, mk(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[12] = '{4'hE, 8'h05, 8'h07, 1'b0, 1'b0, mk(9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)};
        tbl[13] = '{4'h5, 8'h0F, 8'hFF, 1'b0, 1'b0, mk(9'h0F0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[14] = '{4'h2, 8'hF0, 8'h3C, 1'b0, 1'b0, mk(9'h030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[15] = '{4'h1, 8'h10, 8'h0F, 1'b0, 1'b1, mk(9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[16] = '{4'hD, 8'hFF, 8'h81, 1'b1, 1'b1, mk(9'h081, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};

        rst_n = 1'b0; in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00; ci = 1'b0; bi = 1'b0;
        opcode = 4'h0; out_ready = 1'b1; rand_rdy = 1'b0; m_acc = 8'h00;
        tick();
        tick();
        chk("reset_outputs", {out_valid, result_out, c_out, sign_b, zero_b, parity_b, overflow}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", in_ready, 1);

        // Latency: result visible two cycles after the transfer cycle
        drive(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        push(4'h0, mk(9'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        drain();

        // Fixed vectors, issued back to back
        for (int i = 0; i < 17; i++) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].bi, tbl[i].e);
        drain();

        // Accumulator chain, CMP leaves acc untouched
        issue(4'hD, 8'h00, 8'h05, 1'b0, 1'b0, mk(9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(4'hF, 8'h03, 8'h00, 1'b0, 1'b0, mk(9'h008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(4'hF, 8'h10, 8'h00, 1'b0, 1'b0, mk(9'h018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(4'hE, 8'h00, 8'h00, 1'b0, 1'b0, mk(9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(4'hF, 8'h00, 8'h00, 1'b0, 1'b0, mk(9'h018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // Back-pressure: two transfers, then in_ready low while out_ready held low
        out_ready = 1'b0;
        issue_m(4'h0, 8'h01, 8'h02, 1'b0, 1'b0);
        issue_m(4'h2, 8'hFF, 8'h0F, 1'b0, 1'b0);
        drive(4'h4, 8'h0F, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_in_ready_low", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        issue_m(4'h4, 8'h0F, 8'hFF, 1'b0, 1'b0);
        drain();

        // Throughput: one transfer every cycle when the consumer is always ready
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ra;
            ra = 8'($urandom);
            drive(4'hF, ra, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            chk("thruput_in_ready", in_ready, 1);
            if (in_ready) push(4'hF, model(4'hF, ra, 8'h00, 1'b0, 1'b0, m_acc));
            tick();
        end
        drain();

        // Reset with two ops in flight
        issue_m(4'hD, 8'h00, 8'h5A, 1'b0, 1'b0);
        issue_m(4'h0, 8'h33, 8'h44, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {out_valid, result_out, c_out, sign_b, zero_b, parity_b, overflow}, 0);
        exp_q.delete();
        m_acc = 8'h00;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_no_valid", out_valid, 0);
            tick();
        end
        issue_m(4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        drain();

        // Randomized traffic with random back-pressure and input gaps
        rand_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick();
            end else begin
                issue_m(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have parameter OP_W, default 4, opcode width; fixed at 4 for this revision.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operation presented on a_in/b_in/ci/bi/opcode.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port a_in  input  DATA_W  operand A.
REQ-008 SHALL have port b_in  input  DATA_W  operand B.
REQ-009 SHALL have port ci  input  1  carry-in for ADD.
REQ-010 SHALL have port bi  input  1  borrow-in for SUB.
REQ-011 SHALL have port opcode  input  OP_W  operation select.
REQ-012 SHALL have port out_valid  output  1  result_out and flags hold a valid result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-014 SHALL have port result_out  output  DATA_W+1  registered result; bit DATA_W = carry/borrow.
REQ-015 SHALL have ports c_out, sign_b, zero_b, parity_b, overflow  output  1 each  registered flags.

Function
REQ-016 SHALL accept an operation on any rising edge where in_valid && in_ready (transfer).
REQ-017 SHALL implement two stages: S1 registers operands/opcode; S2 computes and registers result plus flags.
REQ-018 SHALL advance S1->S2 when S1 valid && (!S2 valid || out_ready); in_ready = !S1 valid || that advance condition.
REQ-019 SHALL present a result with out_valid high exactly 2 cycles after its input transfer when out_ready is held high; sustained throughput 1 op/cycle.
REQ-020 SHALL hold result_out and all flags stable while out_valid && !out_ready; no op dropped, duplicated or reordered.
REQ-021 SHALL decode opcode: 0 ADD a+b+ci; 1 SUB a-b-bi; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a by 1; 7 SHR a logical by 1; 8 ASR a by 1; 9 ROL a; A ROR a; B INC a; C DEC a; D PASS b; E CMP; F ACC (acc + a).
REQ-022 SHALL compute ADD/INC/ACC as zero-extended DATA_W+1-bit sums; SUB/DEC/CMP as {0,a}-{0,b}-bi (DEC: b=1, bi=0) so bit DATA_W = borrow.
REQ-023 SHALL set result_out[DATA_W]=0 for logic/pass ops; for SHL/SHR/ASR/ROL/ROR it SHALL hold the bit shifted out.
REQ-024 SHALL make CMP update flags as SUB but drive result_out = 0 and not update acc.
REQ-025 SHALL set c_out = result_out[DATA_W]; sign_b = result MSB (DATA_W-1); zero_b = (result[DATA_W-1:0]==0); parity_b = XOR-reduce of result[DATA_W-1:0]; CMP flags use the internal difference.
REQ-026 SHALL set overflow to signed two's-complement overflow for ADD/SUB/INC/DEC/CMP/ACC, else 0.
REQ-027 SHALL maintain internal register acc (DATA_W) loaded with result[DATA_W-1:0] on every S2 load except CMP.
REQ-028 SHALL make ACC use acc value before the edge on which the ACC op loads S2, i.e. the previous op's result in issue order; back-to-back ACC ops chain with no stall.
REQ-029 SHALL treat simultaneous S2 drain and S1->S2 advance on the same edge as a normal advance.

Reset
REQ-030 SHALL on rst_n low clear S1/S2 valid, acc, result_out and all flags to 0 immediately; in_ready = 1 from the first rising clk after rst_n deasserts.
REQ-031 SHALL discard any in-flight ops on reset mid-operation; no out_valid pulse for them after release.

Verification (DATA_W=8)
REQ-032 SHALL check ADD a=FF b=01 ci=0 -> result_out=100, c_out=1, zero_b=1, overflow=0, out_valid 2 cycles after transfer.
REQ-033 SHALL check SUB a=80 b=01 bi=0 -> result_out=07F, c_out=0, overflow=1, sign_b=0, parity_b=1.
REQ-034 SHALL check out_ready low 4 cycles with in_valid high continuously -> in_ready drops after 2 transfers, outputs frozen, 3 results later in issue order.
REQ-035 SHALL check PASS b=05, ACC a=03, ACC a=10, CMP a=0 b=0 -> results 05, 08, 18, 000 with zero_b=1; next ACC a=00 -> 18.
REQ-036 SHALL check rst_n pulse with two ops in flight -> out_valid=0, result_out=000, acc=0, no stale result after release.
REQ-037 SHALL check ROR a=01 -> result_out=180; ASR a=80 -> result_out=0C0.
